ok_wire_cmd_responder: RTL and testbench

- Device-side responder for host-initiated register transactions carried over plain WireIn/WireOut endpoints.
- The host writes command and data words to two WireIns, then flips a toggle bit. This block detects the toggle, runs one read or write on a simple local register bus, and reports completion through two WireOuts.
- It sits between the okWireIn/okWireOut endpoint instances and user register logic, for example the I2C controller CSRs, all in the ti_clk domain.

---
 rtl/ok_cmd_pkg.sv | 24 ++
 rtl/ok_wire_cmd_responder.sv | 126 ++++++++++++
 tb/tb_ok_wire_cmd_responder.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ok_cmd_pkg.sv
// Shared field positions, FSM states and defaults for the WireIn/WireOut
// command responder.
package ok_cmd_pkg;

    localparam int CMD_TOGGLE_BIT  = 15;
    localparam int CMD_WR_BIT      = 14;

    localparam int STAT_ACK_TOGGLE = 15;
    localparam int STAT_BUSY       = 14;
    localparam int STAT_TIMEOUT    = 13;
    localparam int STAT_LAST_WR    = 12;
    localparam int STAT_COUNT_LSB  = 0;
    localparam int STAT_COUNT_W    = 8;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } cmd_state_t;

endpackage

// File: rtl/ok_wire_cmd_responder.sv
// Turns a host-side toggle handshake on two WireIns into one local register
// read or write, and reports the result on two WireOuts.
module ok_wire_cmd_responder
    import ok_cmd_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic [15:0]       cmd_wire,
    input  logic [DATA_W-1:0] data_wire,
    output logic [15:0]       status_wire,
    output logic [DATA_W-1:0] rdata_wire,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    cmd_state_t              state_reg;
    logic                    last_toggle_reg;
    logic                    toggle_reg;
    logic                    op_write_reg;
    logic                    timed_out_reg;
    logic [TO_W-1:0]         timeout_cnt_reg;
    logic [DATA_W-1:0]       rdata_cap_reg;
    logic [DATA_W-1:0]       rdata_wire_reg;
    logic                    busy_reg;
    logic                    timeout_err_reg;
    logic                    last_op_write_reg;
    logic [STAT_COUNT_W-1:0] done_count_reg;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_wire[13:ADDR_W];

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            last_toggle_reg   <= 1'b0;
            toggle_reg        <= 1'b0;
            op_write_reg      <= 1'b0;
            timed_out_reg     <= 1'b0;
            timeout_cnt_reg   <= '0;
            rdata_cap_reg     <= '0;
            rdata_wire_reg    <= '0;
            busy_reg          <= 1'b0;
            timeout_err_reg   <= 1'b0;
            last_op_write_reg <= 1'b0;
            done_count_reg    <= '0;
            reg_addr          <= '0;
            reg_wdata         <= '0;
            reg_we            <= 1'b0;
            reg_re            <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Everything is latched here so later WireIn changes cannot disturb the access.
                    if (cmd_wire[CMD_TOGGLE_BIT] != last_toggle_reg) begin
                        reg_addr     <= cmd_wire[ADDR_W-1:0];
                        reg_wdata    <= data_wire;
                        op_write_reg <= cmd_wire[CMD_WR_BIT];
                        toggle_reg   <= cmd_wire[CMD_TOGGLE_BIT];
                        reg_we       <= cmd_wire[CMD_WR_BIT];
                        reg_re       <= ~cmd_wire[CMD_WR_BIT];
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timeout_cnt_reg <= '0;
                    timed_out_reg   <= 1'b0;
                    if (reg_ack) begin
                        rdata_cap_reg <= reg_rdata;
                        state_reg     <= DONE;
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (reg_ack) begin
                        rdata_cap_reg <= reg_rdata;
                        state_reg     <= DONE;
                    end else if (timeout_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        timed_out_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (!op_write_reg && !timed_out_reg) begin
                        rdata_wire_reg <= rdata_cap_reg;
                    end
                    timeout_err_reg   <= timed_out_reg;
                    last_op_write_reg <= op_write_reg;
                    done_count_reg    <= done_count_reg + 8'd1;
                    last_toggle_reg   <= toggle_reg;
                    busy_reg          <= 1'b0;
                    state_reg         <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_wire                                        = '0;
        status_wire[STAT_ACK_TOGGLE]                       = last_toggle_reg;
        status_wire[STAT_BUSY]                             = busy_reg;
        status_wire[STAT_TIMEOUT]                          = timeout_err_reg;
        status_wire[STAT_LAST_WR]                          = last_op_write_reg;
        status_wire[STAT_COUNT_LSB +: STAT_COUNT_W]        = done_count_reg;
    end

    assign rdata_wire = rdata_wire_reg;

endmodule

// File: tb/tb_ok_wire_cmd_responder.sv
// Bench for ok_wire_cmd_responder: vector table, hand-written corner cases and
// randomized commands checked against a transaction-level model.
`timescale 1ns/1ps
module tb_ok_wire_cmd_responder;

    localparam int T = 255;

    logic        ti_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cmd_wire = 16'h0000;
    logic [15:0] data_wire = 16'h0000;
    logic [15:0] status_wire;
    logic [15:0] rdata_wire;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = 16'h0000;
    logic        reg_ack = 1'b0;

    ok_wire_cmd_responder #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(T)) dut (
        .ti_clk     (ti_clk),
        .reset      (reset),
        .cmd_wire   (cmd_wire),
        .data_wire  (data_wire),
        .status_wire(status_wire),
        .rdata_wire (rdata_wire),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack)
    );

    always #5 ti_clk = ~ti_clk;

    int cyc = 0;
    always @(posedge ti_clk) cyc <= cyc + 1;

    // Register-bank responder: counts strobes and acks after ack_delay cycles (-1 = never).
    logic [15:0] slave_mem [256];
    int          ack_delay = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    bit          inject_ack = 0;
    int          strobe_cnt = 0;
    int          both_cnt = 0;
    int          strobe_cyc = 0;
    logic [7:0]  strobe_addr = 8'h00;
    logic [15:0] strobe_wdata = 16'h0000;
    logic        strobe_we = 1'b0;

    always @(negedge ti_clk) begin
        reg_ack   = 1'b0;
        reg_rdata = 16'($urandom);
        if (reset) begin
            pend = 0;
        end else if (reg_we || reg_re) begin
            strobe_cnt++;
            if (reg_we && reg_re) both_cnt++;
            strobe_cyc   = cyc;
            strobe_addr  = reg_addr;
            strobe_wdata = reg_wdata;
            strobe_we    = reg_we;
            if (reg_we) slave_mem[reg_addr] = reg_wdata;
            if (ack_delay >= 0) begin
                pend     = 1;
                pend_cnt = ack_delay;
            end
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = slave_mem[strobe_addr];
                pend      = 0;
            end else begin
                pend_cnt--;
            end
        end
        if (inject_ack) begin
            reg_ack    = 1'b1;
            reg_rdata  = 16'hDEAD;
            inject_ack = 0;
        end
    end

    // Transaction-level reference model.
    logic [15:0] model_mem [256];
    logic        model_tog = 1'b0;
    logic [7:0]  model_cnt = 8'h00;
    logic [15:0] model_rdata = 16'h0000;

    task automatic model_reset();
        model_tog   = 1'b0;
        model_cnt   = 8'h00;
        model_rdata = 16'h0000;
    endtask

    task automatic model_exec(input logic [15:0] cmd, input logic [15:0] data,
                              input bit timed_out, output logic [15:0] exp_status);
        bit wr;
        int a;
        wr = cmd[14];
        a  = int'(cmd[7:0]);
        if (wr) model_mem[a] = data;
        else if (!timed_out) model_rdata = model_mem[a];
        model_cnt = model_cnt + 8'd1;
        model_tog = cmd[15];
        exp_status = {cmd[15], 1'b0, timed_out, wr, 4'h0, model_cnt};
    endtask

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_status(input logic tog, input int budget, output int done_cyc, output bit ok);
        ok = 0;
        done_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ti_clk);
            if (status_wire[15] == tog && !status_wire[14]) begin
                ok = 1;
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_cmd(input logic [15:0] cmd, input logic [15:0] data, input int delay,
                           input bit scramble, output int lat, output bit ok, output int nstrobe);
        int s0;
        int done_cyc;
        s0 = strobe_cnt;
        ack_delay = delay;
        @(negedge ti_clk);
        cmd_wire  = cmd;
        data_wire = data;
        if (scramble) begin
            @(posedge ti_clk);
            #1;
            cmd_wire  = {cmd[15], 15'($urandom)};
            data_wire = 16'($urandom);
        end
        wait_status(cmd[15], T + 40, done_cyc, ok);
        lat     = done_cyc - strobe_cyc;
        nstrobe = strobe_cnt - s0;
        $display("txn cmd=0x%04h data=0x%04h delay=%0d status=0x%04h rdata=0x%04h lat=%0d",
                 cmd, data, delay, status_wire, rdata_wire, lat);
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] data;
        int          delay;
        logic [15:0] exp_status;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tv [6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        bit          ok;
        int          ns;
        int          s0;
        int          first_cyc;
        int          dcyc;
        int          dl;
        logic [15:0] st;
        logic [15:0] st2;
        logic [15:0] c;
        logic [15:0] d;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 16'(16'hA500 | i);
            model_mem[i] = 16'(16'hA500 | i);
        end
        slave_mem[8'h34] = 16'h1234;
        model_mem[8'h34] = 16'h1234;

        tv[0] = '{16'hC012, 16'hBEEF,  0, 16'h9001, 16'h0000};
        tv[1] = '{16'h0034, 16'h0000,  3, 16'h0002, 16'h1234};
        tv[2] = '{16'h8056, 16'h0000, -1, 16'hA003, 16'h1234};
        tv[3] = '{16'h0056, 16'h0000,  1, 16'h0004, 16'hA556};
        tv[4] = '{16'hFFAB, 16'h1357,  2, 16'h9005, 16'hA556};
        tv[5] = '{16'h0012, 16'h0000,  0, 16'h0006, 16'hBEEF};

        // Reset state
        repeat (3) @(negedge ti_clk);
        check("rst_status", status_wire, 16'h0000);
        check("rst_rdata", rdata_wire, 16'h0000);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wdata, 16'h0000);
        check("rst_strobes", {reg_we, reg_re}, 2'b00);
        reset = 1'b0;
        repeat (3) @(negedge ti_clk);
        check("idle_no_strobe", strobe_cnt, 0);
        $display("txn reset status=0x%04h", status_wire);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_cmd(tv[i].cmd, tv[i].data, tv[i].delay, 0, lat, ok, ns);
            model_exec(tv[i].cmd, tv[i].data, tv[i].delay < 0, st);
            check($sformatf("v%0d_done", i), ok, 1);
            check($sformatf("v%0d_status", i), status_wire, tv[i].exp_status);
            check($sformatf("v%0d_rdata", i), rdata_wire, tv[i].exp_rdata);
            check($sformatf("v%0d_strobes", i), ns, 1);
            check($sformatf("v%0d_addr", i), strobe_addr, tv[i].cmd[7:0]);
            check($sformatf("v%0d_wdata", i), strobe_wdata, tv[i].data);
            check($sformatf("v%0d_we", i), strobe_we, tv[i].cmd[14]);
            check($sformatf("v%0d_latency", i), lat, (tv[i].delay < 0) ? T + 2 : tv[i].delay + 2);
        end

        // Toggle flip while busy: second write issues in the first IDLE cycle after DONE
        s0 = strobe_cnt;
        ack_delay = 5;
        @(negedge ti_clk);
        cmd_wire  = 16'h8020;
        data_wire = 16'h0000;
        @(posedge ti_clk);
        @(posedge ti_clk);
        #1;
        cmd_wire  = 16'h4010;
        data_wire = 16'h5A5A;
        wait_status(1'b1, T + 40, dcyc, ok);
        check("tgl_first_done", ok, 1);
        first_cyc = strobe_cyc;
        wait_status(1'b0, T + 40, dcyc, ok);
        check("tgl_second_done", ok, 1);
        model_exec(16'h8020, 16'h0000, 0, st);
        model_exec(16'h4010, 16'h5A5A, 0, st);
        check("tgl_status", status_wire, st);
        check("tgl_rdata", rdata_wire, model_rdata);
        check("tgl_strobes", strobe_cnt - s0, 2);
        check("tgl_gap", strobe_cyc - first_cyc, 8);
        check("tgl_addr", strobe_addr, 8'h10);
        check("tgl_wdata", strobe_wdata, 16'h5A5A);
        $display("txn toggle-while-busy status=0x%04h", status_wire);

        // Reset in WAIT, then a late ack
        s0 = strobe_cnt;
        ack_delay = -1;
        @(negedge ti_clk);
        cmd_wire = 16'h8077;
        repeat (4) @(negedge ti_clk);
        check("rw_strobe_before_reset", strobe_cnt - s0, 1);
        reset = 1'b1;
        @(negedge ti_clk);
        @(negedge ti_clk);
        cmd_wire = 16'h0000;
        reset = 1'b0;
        s0 = strobe_cnt;
        @(posedge ti_clk);
        #1;
        inject_ack = 1;
        repeat (3) @(negedge ti_clk);
        check("rw_status", status_wire, 16'h0000);
        check("rw_rdata", rdata_wire, 16'h0000);
        check("rw_addr", reg_addr, 8'h00);
        check("rw_wdata", reg_wdata, 16'h0000);
        check("rw_no_strobe", strobe_cnt - s0, 0);
        $display("txn reset-mid-wait status=0x%04h", status_wire);
        model_reset();
        run_cmd(16'h8034, 16'h0000, 0, 0, lat, ok, ns);
        model_exec(16'h8034, 16'h0000, 0, st);
        check("rw_next_done", ok, 1);
        check("rw_next_status", status_wire, st);
        check("rw_next_rdata", rdata_wire, model_rdata);
        check("rw_next_strobes", ns, 1);

        // Randomized commands through a full done_count wrap
        reset = 1'b1;
        @(negedge ti_clk);
        @(negedge ti_clk);
        cmd_wire = 16'h0000;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            c  = {~model_tog, 1'($urandom), 6'($urandom), 8'($urandom)};
            d  = 16'($urandom);
            dl = int'($urandom_range(0, 4));
            run_cmd(c, d, dl, 1, lat, ok, ns);
            model_exec(c, d, 0, st2);
            check($sformatf("r%0d_done", i), ok, 1);
            check($sformatf("r%0d_status", i), status_wire, st2);
            check($sformatf("r%0d_rdata", i), rdata_wire, model_rdata);
            check($sformatf("r%0d_strobes", i), ns, 1);
            check($sformatf("r%0d_addr", i), strobe_addr, c[7:0]);
            check($sformatf("r%0d_latency", i), lat, dl + 2);
        end
        check("wrap_count", status_wire[7:0], 8'h00);
        check("no_dual_strobe", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
